// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM state encoding and default operand width for seq_divider.
package seq_divider_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division step (shift in next dividend bit, trial-subtract, keep or restore).
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);
  always_comb begin
    q_o   = {rem_i, bit_i} >= {2'b0, div_i};
    rem_o = q_o ? {rem_i[WIDTH-1:0], bit_i} - {1'b0, div_i} : {rem_i[WIDTH-1:0], bit_i};
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, 2*WIDTH / WIDTH, one quotient bit per cycle.
// Define SEQ_DIVIDER_OVF_CHECK_EN to short-circuit operands whose quotient cannot fit in WIDTH bits.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d, step_rem;
  logic [WIDTH-1:0] sh_q, sh_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d, ovf_q, ovf_d;
  logic             step_q, accept, ovf_hit;
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
  assign ovf_hit = dividend[2*WIDTH-1:WIDTH] >= divisor;
`else
  assign ovf_hit = 1'b0;
`endif
  assign accept = start && (state_q != CALC);
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .bit_i(sh_q[WIDTH-1]),
    .div_i(dvs_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );
  // sh_q starts as the low dividend half and fills with quotient bits as they shift out
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    sh_d        = sh_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
    if (state_q == CALC) begin
      if (cnt_q == CW'(WIDTH)) begin
        state_d     = FIN;
        quotient_d  = sh_q;
        remainder_d = rem_q[WIDTH-1:0];
        div_zero_d  = 1'b0;
        ovf_d       = 1'b0;
      end else begin
        rem_d = step_rem;
        sh_d  = {sh_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
      end
    end else if (accept) begin
      if (divisor == '0) begin
        state_d     = FIN;
        quotient_d  = '1;
        remainder_d = dividend[WIDTH-1:0];
        div_zero_d  = 1'b1;
        ovf_d       = 1'b0;
      end else if (ovf_hit) begin
        state_d     = FIN;
        quotient_d  = '1;
        remainder_d = '1;
        div_zero_d  = 1'b0;
        ovf_d       = 1'b1;
      end else begin
        state_d = CALC;
        rem_d   = {1'b0, dividend[2*WIDTH-1:WIDTH]};
        sh_d    = dividend[WIDTH-1:0];
        dvs_d   = divisor;
        cnt_d   = '0;
      end
    end else begin
      state_d = IDLE;
    end
    busy_d = state_d == CALC;
    done_d = state_d == FIN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      sh_q        <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      sh_q        <= sh_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (WIDTH=16).
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_zero, ovf;
  logic [15:0] quotient, remainder;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  // counts rising edges after the current point until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input bit hold, output int lat);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    wait_done(lat);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, done, div_zero, ovf, quotient, remainder} !== 36'h0) begin
      failures++;
      $display("FAIL reset_state: got %h required 0", {busy, done, div_zero, ovf, quotient, remainder});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    start = 1'b1; dividend = 32'h64; divisor = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy: got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    wait_done(lat);
    checks++;
    if (lat != 17) begin failures++; $display("FAIL basic_latency: got %0d required 17", lat); end
    checks++;
    if ({quotient, remainder} !== {16'd14, 16'd2}) begin
      failures++;
      $display("FAIL basic_result: got q=%h r=%h required q=000e r=0002", quotient, remainder);
    end
    checks++;
    if ({busy, div_zero, ovf} !== 3'b000) begin
      failures++;
      $display("FAIL basic_flags: got busy,dz,ovf=%b required 000", {busy, div_zero, ovf});
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b required 0", done); end
  endtask

  task automatic test_vectors;
    logic [31:0] va [5] = '{32'hFFFE_FFFF, 32'h5, 32'h1234_5678, 32'd1000, 32'h64};
    logic [15:0] vb [5] = '{16'hFFFF, 16'd9, 16'h2000, 16'd3, 16'd1};
    logic [15:0] vq [5] = '{16'hFFFF, 16'h0, 16'h91A2, 16'd333, 16'h64};
    logic [15:0] vr [5] = '{16'hFFFE, 16'h5, 16'h1678, 16'd1, 16'h0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], 1'b0, lat);
      checks++;
      if (lat != 17) begin failures++; $display("FAIL vec%0d_latency: got %0d required 17", i, lat); end
      checks++;
      if ({quotient, remainder, div_zero, ovf} !== {vq[i], vr[i], 2'b00}) begin
        failures++;
        $display("FAIL vec%0d_result: got q=%h r=%h dz=%b ovf=%b required q=%h r=%h dz=0 ovf=0",
                 i, quotient, remainder, div_zero, ovf, vq[i], vr[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero;
    int lat;
    run_op(32'h0001_2345, 16'h0, 1'b0, lat);
    checks++;
    if (lat != 0) begin failures++; $display("FAIL dz_latency: got %0d required 0", lat); end
    checks++;
    if ({quotient, remainder, div_zero, ovf, busy} !== {16'hFFFF, 16'h2345, 3'b100}) begin
      failures++;
      $display("FAIL dz_result: got q=%h r=%h dz=%b ovf=%b busy=%b required q=ffff r=2345 dz=1 ovf=0 busy=0",
               quotient, remainder, div_zero, ovf, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, quotient, div_zero} !== {1'b0, 16'hFFFF, 1'b1}) begin
      failures++;
      $display("FAIL dz_hold: got done=%b q=%h dz=%b required done=0 q=ffff dz=1", done, quotient, div_zero);
    end
  endtask

  task automatic test_ovf;
    int lat;
    run_op(32'h0005_0000, 16'd3, 1'b0, lat);
`ifdef SEQ_DIVIDER_OVF_CHECK_EN
    checks++;
    if (lat != 0) begin failures++; $display("FAIL ovf_latency: got %0d required 0", lat); end
    checks++;
    if ({quotient, remainder, div_zero, ovf} !== {16'hFFFF, 16'hFFFF, 2'b01}) begin
      failures++;
      $display("FAIL ovf_result: got q=%h r=%h dz=%b ovf=%b required q=ffff r=ffff dz=0 ovf=1",
               quotient, remainder, div_zero, ovf);
    end
`else
    checks++;
    if (lat != 17) begin failures++; $display("FAIL ovf_latency: got %0d required 17", lat); end
    checks++;
    if ({div_zero, ovf} !== 2'b00) begin
      failures++;
      $display("FAIL ovf_flags: got dz=%b ovf=%b required 0 0", div_zero, ovf);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(32'h0000_FFFF, 16'd1, 1'b1, lat);
    checks++;
    if (lat != 17 || {quotient, remainder} !== {16'hFFFF, 16'h0}) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d q=%h r=%h required lat=17 q=ffff r=0000", lat, quotient, remainder);
    end
    dividend = 32'h64;
    divisor  = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_bubble: got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    wait_done(lat);
    checks++;
    if (lat != 17 || {quotient, remainder} !== {16'd14, 16'd2}) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d q=%h r=%h required lat=17 q=000e r=0002", lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start;
    int lat;
    start = 1'b1; dividend = 32'd1000; divisor = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 32'd50; divisor = 16'd5;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat != 11) begin failures++; $display("FAIL ignore_latency: got %0d required 11", lat); end
    checks++;
    if ({quotient, remainder} !== {16'd333, 16'd1}) begin
      failures++;
      $display("FAIL ignore_result: got q=%h r=%h required q=014d r=0001", quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    start = 1'b1; dividend = 32'h64; divisor = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_zero, ovf, quotient, remainder} !== 36'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h required 0", {busy, done, div_zero, ovf, quotient, remainder});
    end
    #3;
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midreset_no_done: got %0d pulses required 0", seen); end
    run_op(32'h1234_5678, 16'h2000, 1'b0, lat);
    checks++;
    if (lat != 17 || {quotient, remainder} !== {16'h91A2, 16'h1678}) begin
      failures++;
      $display("FAIL midreset_recover: got lat=%0d q=%h r=%h required lat=17 q=91a2 r=1678", lat, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_div_zero;
    test_ovf;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
